// File: rtl/mmio_io_pkg.sv
// Shared constants and types for the MMIO LED/button hub: word address map, LED_CMD layout and
// the Galois LFSR step.
package mmio_io_pkg;

  localparam int unsigned AddrRand     = 5;
  localparam int unsigned AddrLedCmd   = 6;
  localparam int unsigned AddrBtnState = 7;
  localparam int unsigned AddrBtnEvent = 8;
  localparam int unsigned AddrLedState = 9;

  localparam logic [31:0] LfsrMask = 32'h8020_0003;

  // LED_CMD store word: bit0 = on, bits[8:1] = channel, bits[31:16] = duration in ticks.
  typedef struct packed {
    logic [15:0] duration;
    logic [6:0]  rsvd;
    logic [7:0]  channel;
    logic        on;
  } led_cmd_t;

  function automatic logic [31:0] lfsr_next(input logic [31:0] state);
    return (state >> 1) ^ (state[0] ? LfsrMask : 32'h0);
  endfunction

endpackage

// File: rtl/mmio_io_hub_if.sv
// Processor data-memory port as seen by the MMIO hub: store strobe, address, data and read-back.
interface mmio_io_hub_if #(
  parameter int unsigned ADDR_W = 12
) ();

  logic              wren;
  logic [ADDR_W-1:0] address;
  logic [31:0]       data_in;
  logic [31:0]       q_mmio;
  logic              hit;

  modport master (
    output wren,
    output address,
    output data_in,
    input  q_mmio,
    input  hit
  );

  modport slave (
    input  wren,
    input  address,
    input  data_in,
    output q_mmio,
    output hit
  );

endinterface

// File: rtl/btn_debounce.sv
// One button channel: two-flop synchroniser, hold-time debounce counter and accepted level,
// with a one-cycle rise pulse coincident with the accepted 0->1 flip.
module btn_debounce #(
  parameter int unsigned DEBOUNCE_CYC = 500000
) (
  input  logic clock,
  input  logic reset,
  input  logic raw,
  output logic level,
  output logic rise
);

  localparam int unsigned CntW = (DEBOUNCE_CYC > 0) ? $clog2(DEBOUNCE_CYC + 1) : 1;

  logic            sync1_q, sync2_q;
  logic            level_q, level_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic            differs;
  logic            flip;

  assign differs = (sync2_q != level_q);
  assign flip    = differs && (cnt_q == CntW'(DEBOUNCE_CYC));

  always_comb begin
    cnt_d   = '0;
    level_d = level_q;
    if (flip) begin
      level_d = ~level_q;
    end else if (differs) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      level_q <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= raw;
      sync2_q <= sync1_q;
      level_q <= level_d;
      cnt_q   <= cnt_d;
    end
  end

  assign level = level_q;
  assign rise  = flip & ~level_q;

endmodule

// File: rtl/mmio_io_hub.sv
// Memory-mapped I/O hub: RAND LFSR, self-timed LED pulses on a shared tick prescaler, debounced
// buttons with sticky W1C press events, and combinational register read-back.
module mmio_io_hub
  import mmio_io_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned ADDR_W       = 12,
  parameter int unsigned TICK_CYC     = 50000,
  parameter int unsigned DEBOUNCE_CYC = 500000,
  parameter logic [31:0] LFSR_SEED    = 32'h0000_ACE1
) (
  input  logic            clock,
  input  logic            reset,
  mmio_io_hub_if.slave    bus,
  input  logic [N_CH-1:0] buttons,
  output logic [N_CH-1:0] leds
);

  localparam int unsigned TickW = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;

  // Address decode
  logic sel_rand, sel_led_cmd, sel_btn_state, sel_btn_event, sel_led_state;

  assign sel_rand      = (bus.address == ADDR_W'(AddrRand));
  assign sel_led_cmd   = (bus.address == ADDR_W'(AddrLedCmd));
  assign sel_btn_state = (bus.address == ADDR_W'(AddrBtnState));
  assign sel_btn_event = (bus.address == ADDR_W'(AddrBtnEvent));
  assign sel_led_state = (bus.address == ADDR_W'(AddrLedState));

  // Tick prescaler, free-running and untouched by commands
  logic [TickW-1:0] presc_q, presc_d;
  logic             tick;

  assign tick    = (presc_q == TickW'(TICK_CYC - 1));
  assign presc_d = tick ? '0 : presc_q + TickW'(1);

  // LFSR
  logic [31:0] lfsr_q;

  // LED command decode and per-channel timers
  led_cmd_t        cmd;
  logic            cmd_valid;
  logic [N_CH-1:0] leds_q, leds_d;
  logic [15:0]     timer_q [N_CH];
  logic [15:0]     timer_d [N_CH];
  logic            unused_cmd_rsvd;

  assign cmd             = led_cmd_t'(bus.data_in);
  assign cmd_valid       = bus.wren && sel_led_cmd && (32'(cmd.channel) < N_CH);
  assign unused_cmd_rsvd = ^cmd.rsvd;

  // A command on the expiry edge takes priority over the timer.
  always_comb begin
    leds_d  = leds_q;
    timer_d = timer_q;
    for (int unsigned c = 0; c < N_CH; c++) begin
      if (cmd_valid && (32'(cmd.channel) == c)) begin
        leds_d[c]  = cmd.on;
        timer_d[c] = cmd.on ? cmd.duration : 16'd0;
      end else if (tick && (timer_q[c] != 16'd0)) begin
        timer_d[c] = timer_q[c] - 16'd1;
        if (timer_q[c] == 16'd1) begin
          leds_d[c] = 1'b0;
        end
      end
    end
  end

  // Buttons
  logic [N_CH-1:0] btn_level;
  logic [N_CH-1:0] btn_rise;

  for (genvar g = 0; g < N_CH; g++) begin : g_btn
    btn_debounce #(
      .DEBOUNCE_CYC(DEBOUNCE_CYC)
    ) u_btn (
      .clock(clock),
      .reset(reset),
      .raw  (buttons[g]),
      .level(btn_level[g]),
      .rise (btn_rise[g])
    );
  end

  // Sticky events: a same-edge rise beats the W1C clear.
  logic [N_CH-1:0] evt_q, evt_d;
  logic [N_CH-1:0] w1c;

  always_comb begin
    w1c = '0;
    if (bus.wren && sel_btn_event) begin
      for (int unsigned i = 0; (i < N_CH) && (i < 32); i++) begin
        w1c[i] = bus.data_in[i];
      end
    end
    evt_d = (evt_q & ~w1c) | btn_rise;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      presc_q <= '0;
      lfsr_q  <= LFSR_SEED;
      leds_q  <= '0;
      evt_q   <= '0;
      for (int unsigned c = 0; c < N_CH; c++) begin
        timer_q[c] <= 16'd0;
      end
    end else begin
      presc_q <= presc_d;
      lfsr_q  <= lfsr_next(lfsr_q);
      leds_q  <= leds_d;
      evt_q   <= evt_d;
      timer_q <= timer_d;
    end
  end

  assign leds = leds_q;

  // Read-back; channels above bit 31 are not visible on the 32-bit bus.
  logic [31:0] lvl_rd, evt_rd, led_rd;

  always_comb begin
    lvl_rd = '0;
    evt_rd = '0;
    led_rd = '0;
    for (int unsigned i = 0; (i < N_CH) && (i < 32); i++) begin
      lvl_rd[i] = btn_level[i];
      evt_rd[i] = evt_q[i];
      led_rd[i] = leds_q[i];
    end
  end

  always_comb begin
    bus.q_mmio = 32'h0;
    bus.hit    = 1'b1;
    if (sel_rand) begin
      bus.q_mmio = lfsr_q;
    end else if (sel_btn_state) begin
      bus.q_mmio = lvl_rd;
    end else if (sel_btn_event) begin
      bus.q_mmio = evt_rd;
    end else if (sel_led_state) begin
      bus.q_mmio = led_rd;
    end else if (!sel_led_cmd) begin
      bus.hit = 1'b0;
    end
  end

endmodule

// File: tb/tb_mmio_io_hub.sv
// Bench for mmio_io_hub: directed scenarios plus random traffic, checked every cycle against a
// behavioural model (tick deadlines, sample-window debounce, arithmetic LFSR).
module tb_mmio_io_hub;

  localparam int unsigned NCh     = 4;
  localparam int unsigned TickCyc = 4;
  localparam int unsigned DebCyc  = 8;
  localparam int unsigned AddrW   = 12;
  localparam logic [31:0] Seed    = 32'h0000_ACE1;
  localparam longint      Forever = 64'sh7fff_ffff_ffff_ffff;

  logic           clock = 1'b0;
  logic           reset;
  logic [NCh-1:0] buttons;
  logic [NCh-1:0] leds;

  mmio_io_hub_if #(.ADDR_W(AddrW)) bus ();

  mmio_io_hub #(
    .N_CH        (NCh),
    .ADDR_W      (AddrW),
    .TICK_CYC    (TickCyc),
    .DEBOUNCE_CYC(DebCyc),
    .LFSR_SEED   (Seed)
  ) dut (
    .clock  (clock),
    .reset  (reset),
    .bus    (bus),
    .buttons(buttons),
    .leds   (leds)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  // Behavioural model state
  logic [31:0]    m_lfsr;
  longint         m_ticks;           // tick strobes seen since reset
  longint         m_dl [NCh];        // LED is on while m_ticks < m_dl
  int             m_cyc;             // edges since reset
  bit [NCh-1:0]   m_level;
  bit [NCh-1:0]   m_evt;
  bit             m_hist [NCh][DebCyc+2];  // [0] = raw sampled on the previous edge

  function automatic logic [31:0] gal(input logic [31:0] s);
    logic [31:0] r;
    r = s / 2;
    if (s % 2 == 1) r = r ^ 32'h8020_0003;
    return r;
  endfunction

  function automatic logic [NCh-1:0] m_leds();
    logic [NCh-1:0] r;
    for (int c = 0; c < NCh; c++) r[c] = (m_ticks < m_dl[c]);
    return r;
  endfunction

  function automatic logic [31:0] m_read(input logic [AddrW-1:0] a);
    case (int'(a))
      5:       return m_lfsr;
      7:       return 32'(m_level);
      8:       return 32'(m_evt);
      9:       return 32'(m_leds());
      default: return 32'h0;
    endcase
  endfunction

  function automatic logic m_hit(input logic [AddrW-1:0] a);
    return (a >= 5) && (a <= 9);
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_edge();
    bit [NCh-1:0] rise;
    bit           all_diff;
    int unsigned  ch;
    int unsigned  dur;
    if (reset) begin
      m_lfsr  = Seed;
      m_ticks = 0;
      m_cyc   = 0;
      m_level = '0;
      m_evt   = '0;
      for (int c = 0; c < NCh; c++) begin
        m_dl[c] = 0;
        for (int k = 0; k < DebCyc + 2; k++) m_hist[c][k] = 1'b0;
      end
    end else begin
      if (m_cyc % TickCyc == TickCyc - 1) m_ticks++;
      m_cyc++;
      m_lfsr = gal(m_lfsr);
      rise = '0;
      // Accepted once the synced samples (raw two edges back) differed for DebCyc+1 edges.
      for (int c = 0; c < NCh; c++) begin
        all_diff = 1'b1;
        for (int k = 1; k <= DebCyc + 1; k++) if (m_hist[c][k] == m_level[c]) all_diff = 1'b0;
        if (all_diff) begin
          m_level[c] = ~m_level[c];
          rise[c]    = m_level[c];
        end
      end
      if (bus.wren && bus.address == 8) m_evt = m_evt & ~bus.data_in[NCh-1:0];
      m_evt = m_evt | rise;
      ch  = int'(bus.data_in[8:1]);
      dur = int'(bus.data_in[31:16]);
      if (bus.wren && bus.address == 6 && ch < NCh) begin
        if (!bus.data_in[0])  m_dl[ch] = 0;
        else if (dur == 0)    m_dl[ch] = Forever;
        else                  m_dl[ch] = m_ticks + longint'(dur);
      end
      for (int c = 0; c < NCh; c++) begin
        for (int k = DebCyc + 1; k > 0; k--) m_hist[c][k] = m_hist[c][k-1];
        m_hist[c][0] = buttons[c];
      end
    end
  endtask

  task automatic step();
    @(posedge clock);
    model_edge();
    #2;
  endtask

  task automatic wr(input int a, input logic [31:0] d);
    bus.wren    = 1'b1;
    bus.address = AddrW'(a);
    bus.data_in = d;
    step();
    bus.wren    = 1'b0;
    bus.data_in = 32'h0;
  endtask

  task automatic rd(input int a, output logic [31:0] q);
    bus.address = AddrW'(a);
    #1;
    q = bus.q_mmio;
  endtask

  always @(negedge clock) begin
    if (chk_en) begin
      check("leds", 32'(leds), 32'(m_leds()));
      check("hit", 32'(bus.hit), 32'(m_hit(bus.address)));
      check("q_mmio", bus.q_mmio, m_read(bus.address));
    end
  end

  initial begin
    logic [31:0] q;
    int          on_cnt;
    int          n_str;

    reset       = 1'b1;
    bus.wren    = 1'b0;
    bus.address = AddrW'(5);
    bus.data_in = 32'h0;
    buttons     = '0;
    #2;
    step();
    chk_en = 1'b1;
    step();
    check("rand_seed", bus.q_mmio, 32'h0000_ACE1);
    reset = 1'b0;
    step();
    check("rand_next", bus.q_mmio, 32'h8020_5673);
    rd(9, q);
    check("led_state_reset", q, 32'h0);
    rd(6, q);
    check("led_cmd_reads_zero", q, 32'h0);

    // Timed pulse, ch2, D=3: on right after the store, off on the 3rd strobe.
    wr(6, 32'h0003_0005);
    check("pulse_on", 32'(leds), 32'h4);
    on_cnt = 1;
    for (int i = 0; i < 20; i++) begin
      step();
      if (leds[2]) on_cnt++;
    end
    check("pulse_len_in_range", 32'((on_cnt >= 9) && (on_cnt <= 12)), 32'h1);

    // Restart on the edge of the 2nd strobe: 12 more cycles lit from that store.
    wr(6, 32'h0003_0005);
    n_str = 0;
    for (int i = 0; i < 20 && n_str < 1; i++) begin
      if (m_cyc % TickCyc == TickCyc - 1) n_str++;
      step();
    end
    for (int i = 0; i < 8 && (m_cyc % TickCyc) != TickCyc - 1; i++) step();
    wr(6, 32'h0003_0005);
    check("ext_on", 32'(leds[2]), 32'h1);
    on_cnt = 0;
    for (int i = 0; i < 16; i++) begin
      step();
      if (leds[2]) on_cnt++;
    end
    check("ext_len", 32'(on_cnt), 32'd11);

    // Steady on / off and out-of-range channels.
    wr(6, 32'h0000_0003);
    check("steady_on", 32'(leds), 32'h2);
    wr(6, 32'h0000_0012);
    check("ch9_off_ignored", 32'(leds), 32'h2);
    wr(6, 32'h0000_0002);
    check("steady_off", 32'(leds), 32'h0);
    wr(6, 32'h0005_0013);
    check("ch9_on_ignored", 32'(leds), 32'h0);

    // Clean press on ch0: accepted on the 11th edge after the raw change.
    bus.address = AddrW'(7);
    buttons[0] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    check("btn_not_yet", bus.q_mmio, 32'h0);
    step();
    check("btn_state", bus.q_mmio, 32'h1);
    rd(8, q);
    check("btn_event", q, 32'h1);
    step();
    buttons[0] = 1'b0;
    buttons[3] = 1'b1;
    for (int i = 0; i < 5; i++) step();
    buttons[3] = 1'b0;
    for (int i = 0; i < 14; i++) step();
    rd(7, q);
    check("glitch_state", q, 32'h0);
    rd(8, q);
    check("glitch_event", q, 32'h1);

    wr(8, 32'h1);
    rd(8, q);
    check("w1c_clear", q, 32'h0);

    // W1C on the same edge as a new rise: the set wins.
    buttons[0] = 1'b1;
    for (int i = 0; i < 10; i++) step();
    wr(8, 32'h1);
    rd(8, q);
    check("w1c_vs_rise", q, 32'h1);
    rd(7, q);
    check("btn_state_again", q, 32'h1);

    // Reset during a long pulse with an event pending.
    wr(6, 32'h0064_0001);
    for (int i = 0; i < 3; i++) step();
    check("long_pulse_on", 32'(leds), 32'h1);
    reset = 1'b1;
    step();
    check("reset_leds", 32'(leds), 32'h0);
    rd(5, q);
    check("reset_rand", q, 32'h0000_ACE1);
    rd(7, q);
    check("reset_btn_state", q, 32'h0);
    rd(8, q);
    check("reset_btn_event", q, 32'h0);
    rd(9, q);
    check("reset_led_state", q, 32'h0);
    reset = 1'b0;

    // Random traffic.
    for (int i = 0; i < 1500; i++) begin
      reset    = ($urandom_range(0, 399) == 0);
      bus.wren = ($urandom_range(0, 99) < 30);
      if ($urandom_range(0, 4) == 0) bus.address = AddrW'($urandom);
      else                           bus.address = AddrW'($urandom_range(4, 10));
      if (bus.address == 6) begin
        bus.data_in = {16'($urandom_range(0, 5)), 7'($urandom), 8'($urandom_range(0, 5)),
                       1'($urandom)};
      end else begin
        bus.data_in = $urandom;
      end
      for (int c = 0; c < NCh; c++) begin
        if ($urandom_range(0, 13) == 0) buttons[c] = ~buttons[c];
      end
      step();
    end

    bus.wren = 1'b0;
    reset    = 1'b0;
    step();
    chk_en = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mmio_io_hub.md
# mmio_io_hub

Parametrised memory-mapped I/O hub for the game board. It replaces the fixed random-read and LED-flash decode with one block that serves N_CH LED/button channels. It adds self-timed LED pulses, debounced buttons with sticky press events, and readable status. It sits between the processor's data-memory port and the board pins; the top level muxes `q_mmio` onto the load path whenever `hit` is high.

## Interface
Parameters:
- `N_CH`, 4: LED/button channel count, 1..64.
- `ADDR_W`, 12: data-memory address width.
- `TICK_CYC`, 50000: clock cycles per pulse tick (1 ms at 50 MHz).
- `DEBOUNCE_CYC`, 500000: cycles a synced button level must hold before it is accepted.
- `LFSR_SEED`, 32'h0000_ACE1: LFSR reset value; must be nonzero.

Ports:
- `clock` in 1: single clock.
- `reset` in 1: synchronous, active-high.
- `wren` in 1: processor store strobe.
- `address` in ADDR_W: data-memory word address.
- `data_in` in 32: store data.
- `q_mmio` out 32: read data, combinational from `address`.
- `hit` out 1: `address` decodes to a register in this block.
- `buttons` in N_CH: raw, asynchronous, active-high.
- `leds` out N_CH: registered, active-high.

## Operation
Address map (word addresses):
- 5, RAND, R: LFSR state.
- 6, LED_CMD, W: LED command.
  - bit0 = on.
  - bits[8:1] = channel.
  - bits[31:16] = duration in ticks.
- 7, BTN_STATE, R: debounced levels, low N_CH bits, rest 0.
- 8, BTN_EVENT, R/W1C: sticky press events. Writing 1 to a bit clears it.
- 9, LED_STATE, R: current `leds`.
- Other addresses: `hit`=0, `q_mmio`=0.
- Writes to read-only addresses are ignored.

LED_CMD rules:
- Channel ≥ N_CH: the whole command is ignored.
- on=0: LED off, timer cancelled.
- on=1, duration=0: steady on until the next command for that channel.
- on=1, duration=D>0: LED on, timer loaded with D. The LED turns off on the D-th tick strobe after the write edge.
- A new command to a channel that is currently timed restarts or cancels its timer.

Ticks:
- One shared free-running prescaler counts 0..TICK_CYC-1.
- It emits a one-cycle strobe when the count wraps.
- It is not reset by commands.

Buttons (per channel):
- Two-flop synchroniser, then a debounce counter.
- The counter increments while the synced level differs from the debounced level. It clears when the two are equal.
- When the counter reaches DEBOUNCE_CYC, the debounced level flips and the counter clears.
- A debounced 0→1 transition sets that channel's BTN_EVENT bit.

LFSR:
- 32-bit Galois, mask 32'h8020_0003.
- Shifts right every cycle outside reset.
- RAND returns the current state.

## Timing
- Reset values:
  - `leds`=0.
  - All timers, debounce counters, synchronisers, debounced levels and events are 0.
  - Prescaler is 0.
  - LFSR = LFSR_SEED.
- Reset asserted mid-pulse: LEDs are off after the reset edge.
- Command latency: a store at edge k drives `leds` from edge k onward, i.e. visible in the cycle after the store.
- Pulse length with TICK_CYC=1 is exactly D cycles of `leds`=1.
- Button latency: a clean press becomes visible in BTN_STATE 2 + DEBOUNCE_CYC cycles after the raw edge is sampled. The event bit sets on the same edge.
- A glitch shorter than DEBOUNCE_CYC cycles produces no change.
- Simultaneous events:
  - A LED_CMD write and timer expiry on the same channel and edge: the write wins.
  - A W1C clear and a new press event on the same bit and edge: set wins.
- Timer decrements only on tick strobes. A timer at 0 is idle.

## Structure
- Package `mmio_io_pkg` holds:
  - address constants (RAND=5 … LED_STATE=9);
  - LED_CMD field positions;
  - LFSR mask.
- One sub-module, `btn_debounce`: synchroniser, counter and level for one channel. It exports `level` and a `rise` pulse. It is generated N_CH times.
- LED timers, prescaler, LFSR and decode stay in the top module.

## Test plan
Bench parameters: TICK_CYC=4, DEBOUNCE_CYC=8, N_CH=4.
- Reset, then read 5 and 9 → RAND=32'h0000_ACE1 on the first cycle after reset; LED_STATE=0; RAND changes every following cycle and matches the model.
- Store 32'h0003_0005 to 6 (ch2, on, D=3) → `leds`=4'b0100 next cycle and off exactly on the 3rd tick strobe. Repeat the store at the 2nd strobe → the pulse extends by 3 more ticks.
- Store 32'h0000_0003 (ch1 steady), then 32'h0000_0002 → led1 on, then off one cycle after the second store. Store with channel 9 → `leds` unchanged.
- Hold `buttons[0]`=1 for 12 cycles → BTN_STATE=1 after 10 cycles and BTN_EVENT=1; a 5-cycle pulse on `buttons[3]` → no change.
- With BTN_EVENT bit0 set, store 1 to 8 → bit clears. Store 1 on the same edge as a new rise on ch0 → the bit stays set.
- Assert `reset` during a D=100 pulse and with an event pending → all outputs and registers return to reset values on the next edge.
